// File: rtl/riscv_timer_pkg.sv
// Purpose: shared constants for the memory-mapped machine timer (register
//          select encodings, widths and register reset values).
package riscv_timer_pkg;

   localparam int unsigned TIMER_DW = 64;
   localparam int unsigned TIMER_SW = TIMER_DW / 8;

   localparam logic [1:0] TIMER_SEL_MTIME    = 2'b00;
   localparam logic [1:0] TIMER_SEL_MTIMECMP = 2'b01;
   localparam logic [1:0] TIMER_SEL_CTRL     = 2'b10;

   localparam logic [TIMER_DW-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
   // enable=1, divisor=0
   localparam logic [TIMER_DW-1:0] CTRL_RST     = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/riscv_timer_clint_if.sv
// Purpose: timer access bus between the memory stage and the timer.
// Signals: wren/rden/regsel/wdata/wstrb (request, from master),
//          rdata/rvalid (registered read response), mtip (interrupt),
//          tick (mtime increment pulse).
interface riscv_timer_clint_if;
   import riscv_timer_pkg::*;

   logic                i_riscv_timer_wren;
   logic                i_riscv_timer_rden;
   logic [1:0]          i_riscv_timer_regsel;
   logic [TIMER_DW-1:0] i_riscv_timer_wdata;
   logic [TIMER_SW-1:0] i_riscv_timer_wstrb;
   logic [TIMER_DW-1:0] o_riscv_timer_rdata;
   logic                o_riscv_timer_rvalid;
   logic                o_riscv_timer_mtip;
   logic                o_riscv_timer_tick;

   modport master (
      output i_riscv_timer_wren, i_riscv_timer_rden, i_riscv_timer_regsel,
             i_riscv_timer_wdata, i_riscv_timer_wstrb,
      input  o_riscv_timer_rdata, o_riscv_timer_rvalid, o_riscv_timer_mtip,
             o_riscv_timer_tick
   );

   modport slave (
      input  i_riscv_timer_wren, i_riscv_timer_rden, i_riscv_timer_regsel,
             i_riscv_timer_wdata, i_riscv_timer_wstrb,
      output o_riscv_timer_rdata, o_riscv_timer_rvalid, o_riscv_timer_mtip,
             o_riscv_timer_tick
   );

endinterface

// File: rtl/riscv_timer_prescaler.sv
// Purpose: divides the clock into mtime increment ticks.
// Ports: i_clk/i_rst clock and async active-high reset; i_en enable;
//        i_div divisor (tick every i_div+1 cycles); i_clr restarts the count;
//        o_tick combinational tick for the current cycle.
module riscv_timer_prescaler #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic [PRESC_W-1:0] i_div,
   input  logic               i_clr,
   output logic               o_tick
);

   logic [PRESC_W-1:0] r_presc_cnt;
   logic               w_tick;

   // Gated by reset so no tick is seen while the block is held in reset.
   assign w_tick = i_en & (r_presc_cnt == i_div) & ~i_rst;
   assign o_tick = w_tick;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc_cnt <= '0;
      end else if (i_clr || w_tick) begin
         r_presc_cnt <= '0;
      end else if (i_en) begin
         r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/riscv_timer_clint.sv
// Purpose: machine timer with mtime, mtimecmp and prescaler ctrl registers,
//          byte-strobed writes, 1-cycle registered reads and MTIP generation.
// Ports: i_riscv_timer_clk clock; i_riscv_timer_rst async active-high reset;
//        io_riscv_timer_bus timer access bus (slave side).
module riscv_timer_clint
   import riscv_timer_pkg::*;
#(
   parameter int unsigned PRESC_W = 16
) (
   input  logic                     i_riscv_timer_clk,
   input  logic                     i_riscv_timer_rst,
   riscv_timer_clint_if.slave       io_riscv_timer_bus
);

   localparam int unsigned CTRL_W = PRESC_W + 1;

   logic [TIMER_DW-1:0] r_mtime;
   logic [TIMER_DW-1:0] r_mtimecmp;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [TIMER_DW-1:0] r_rdata;
   logic                r_rvalid;
   logic                r_mtip;

   logic                w_tick;
   logic                w_wr_mtime;
   logic                w_wr_cmp;
   logic                w_wr_ctrl;
   logic                w_ctrl_clr;
   logic [TIMER_DW-1:0] w_ctrl_view;
   logic [TIMER_DW-1:0] w_mtime_nxt;
   logic [TIMER_DW-1:0] w_cmp_nxt;
   logic [CTRL_W-1:0]   w_ctrl_nxt;
   logic [TIMER_DW-1:0] w_rd_mux;

   // Replace only the strobed byte lanes of the old value.
   function automatic logic [TIMER_DW-1:0] f_byte_merge(
      input logic [TIMER_DW-1:0] old_val,
      input logic [TIMER_DW-1:0] wr_val,
      input logic [TIMER_SW-1:0] strb
   );
      logic [TIMER_DW-1:0] res;
      res = old_val;
      for (int k = 0; k < int'(TIMER_SW); k++) begin
         if (strb[k]) res[8*k +: 8] = wr_val[8*k +: 8];
      end
      return res;
   endfunction

   assign w_wr_mtime  = io_riscv_timer_bus.i_riscv_timer_wren &
                        (io_riscv_timer_bus.i_riscv_timer_regsel == TIMER_SEL_MTIME);
   assign w_wr_cmp    = io_riscv_timer_bus.i_riscv_timer_wren &
                        (io_riscv_timer_bus.i_riscv_timer_regsel == TIMER_SEL_MTIMECMP);
   assign w_wr_ctrl   = io_riscv_timer_bus.i_riscv_timer_wren &
                        (io_riscv_timer_bus.i_riscv_timer_regsel == TIMER_SEL_CTRL);
   // An all-zero strobe is a no-op, so it must not restart the prescaler either.
   assign w_ctrl_clr  = w_wr_ctrl & (|io_riscv_timer_bus.i_riscv_timer_wstrb);
   assign w_ctrl_view = TIMER_DW'(r_ctrl);

   riscv_timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .i_clk  (i_riscv_timer_clk),
      .i_rst  (i_riscv_timer_rst),
      .i_en   (r_ctrl[0]),
      .i_div  (r_ctrl[CTRL_W-1:1]),
      .i_clr  (w_ctrl_clr),
      .o_tick (w_tick)
   );

   // Next register values; a write to mtime overrides a same-cycle tick.
   always_comb begin
      w_mtime_nxt = r_mtime;
      w_cmp_nxt   = r_mtimecmp;
      w_ctrl_nxt  = r_ctrl;
      if (w_wr_mtime) begin
         w_mtime_nxt = f_byte_merge(r_mtime, io_riscv_timer_bus.i_riscv_timer_wdata,
                                    io_riscv_timer_bus.i_riscv_timer_wstrb);
      end else if (w_tick) begin
         w_mtime_nxt = r_mtime + TIMER_DW'(1);
      end
      if (w_wr_cmp) begin
         w_cmp_nxt = f_byte_merge(r_mtimecmp, io_riscv_timer_bus.i_riscv_timer_wdata,
                                  io_riscv_timer_bus.i_riscv_timer_wstrb);
      end
      if (w_wr_ctrl) begin
         w_ctrl_nxt = CTRL_W'(f_byte_merge(w_ctrl_view, io_riscv_timer_bus.i_riscv_timer_wdata,
                                           io_riscv_timer_bus.i_riscv_timer_wstrb));
      end
   end

   // Read mux over pre-edge register values.
   always_comb begin
      w_rd_mux = '0;
      case (io_riscv_timer_bus.i_riscv_timer_regsel)
         TIMER_SEL_MTIME:    w_rd_mux = r_mtime;
         TIMER_SEL_MTIMECMP: w_rd_mux = r_mtimecmp;
         TIMER_SEL_CTRL:     w_rd_mux = w_ctrl_view;
         default:            w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_riscv_timer_clk or posedge i_riscv_timer_rst) begin
      if (i_riscv_timer_rst) begin
         r_mtime    <= '0;
         r_mtimecmp <= MTIMECMP_RST;
         r_ctrl     <= CTRL_W'(CTRL_RST);
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_mtip     <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_cmp_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_rvalid   <= io_riscv_timer_bus.i_riscv_timer_rden;
         if (io_riscv_timer_bus.i_riscv_timer_rden) r_rdata <= w_rd_mux;
         r_mtip     <= (w_mtime_nxt >= w_cmp_nxt);
      end
   end

   assign io_riscv_timer_bus.o_riscv_timer_rdata  = r_rdata;
   assign io_riscv_timer_bus.o_riscv_timer_rvalid = r_rvalid;
   assign io_riscv_timer_bus.o_riscv_timer_mtip   = r_mtip;
   assign io_riscv_timer_bus.o_riscv_timer_tick   = w_tick;

endmodule

// File: tb/tb_riscv_timer_clint.sv
// Purpose: randomized + directed scoreboard bench for riscv_timer_clint.
module tb_riscv_timer_clint;

   typedef struct {
      int          cyc;
      logic [63:0] data;
   } rd_t;

   typedef struct {
      int   cyc;
      logic val;
   } mt_t;

   localparam logic [63:0] CTRL_MASK = 64'h0000_0000_0001_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;

   riscv_timer_clint_if bus ();

   riscv_timer_clint #(
      .PRESC_W (16)
   ) dut (
      .i_riscv_timer_clk  (clk),
      .i_riscv_timer_rst  (rst),
      .io_riscv_timer_bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   rd_t rd_q[$];
   mt_t mtip_q[$];
   logic exp_tick   = 1'b0;
   logic tick_valid = 1'b0;
   logic [63:0] last_rdata = '0;

   // Reference model state
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   logic [63:0] m_ctrl;
   int          m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] w,
                                          input logic [7:0] s);
      logic [63:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) if (s[k]) m = m | (64'hFF << (8*k));
      return (o & ~m) | (w & m);
   endfunction

   // Drive one cycle's request and advance the model by one clock edge.
   task automatic apply(input logic w, input logic r, input logic [1:0] s,
                        input logic [63:0] wd, input logic [7:0] st);
      logic [63:0] n_mtime;
      logic [63:0] rv;
      logic        t;
      rd_t         re;
      mt_t         me;
      cyc++;
      bus.i_riscv_timer_wren   = w;
      bus.i_riscv_timer_rden   = r;
      bus.i_riscv_timer_regsel = s;
      bus.i_riscv_timer_wdata  = wd;
      bus.i_riscv_timer_wstrb  = st;
      t = m_ctrl[0] && (m_cnt == int'(m_ctrl[16:1]));
      exp_tick   = t;
      tick_valid = 1'b1;
      if (r) begin
         case (s)
            2'd0:    rv = m_mtime;
            2'd1:    rv = m_cmp;
            2'd2:    rv = m_ctrl;
            default: rv = '0;
         endcase
         re.cyc  = cyc;
         re.data = rv;
         rd_q.push_back(re);
      end
      if (t) n_mtime = m_mtime + 64'd1;
      else   n_mtime = m_mtime;
      if (t)              m_cnt = 0;
      else if (m_ctrl[0]) m_cnt++;
      if (w && st != 8'h00) begin
         case (s)
            2'd0: n_mtime = bmerge(m_mtime, wd, st);
            2'd1: m_cmp   = bmerge(m_cmp, wd, st);
            2'd2: begin
               m_ctrl = bmerge(m_ctrl, wd, st) & CTRL_MASK;
               m_cnt  = 0;
            end
            default: ;
         endcase
      end
      m_mtime = n_mtime;
      me.cyc  = cyc;
      me.val  = (m_mtime >= m_cmp);
      mtip_q.push_back(me);
   endtask

   task automatic step(input logic w, input logic r, input logic [1:0] s,
                       input logic [63:0] wd, input logic [7:0] st);
      @(posedge clk);
      #1;
      apply(w, r, s, wd, st);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 2'd0, 64'd0, 8'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.i_riscv_timer_wren  = 1'b0;
      bus.i_riscv_timer_rden  = 1'b0;
      bus.i_riscv_timer_regsel = 2'd0;
      bus.i_riscv_timer_wdata = '0;
      bus.i_riscv_timer_wstrb = '0;
      rd_q.delete();
      mtip_q.delete();
      tick_valid = 1'b0;
      m_mtime = '0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ctrl  = 64'd1;
      m_cnt   = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      apply(1'b0, 1'b0, 2'd0, 64'd0, 8'd0);
   endtask

   // Monitor: compares DUT outputs against queued expectations each cycle.
   always @(negedge clk) begin
      rd_t re;
      mt_t me;
      if (rst) begin
         chk("rst_rdata",  bus.o_riscv_timer_rdata,  64'd0);
         chk("rst_rvalid", 64'(bus.o_riscv_timer_rvalid), 64'd0);
         chk("rst_mtip",   64'(bus.o_riscv_timer_mtip),   64'd0);
         chk("rst_tick",   64'(bus.o_riscv_timer_tick),   64'd0);
         last_rdata = '0;
      end else begin
         if (tick_valid) chk("tick", 64'(bus.o_riscv_timer_tick), 64'(exp_tick));
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc - 1) begin
            re = rd_q.pop_front();
            chk("rvalid", 64'(bus.o_riscv_timer_rvalid), 64'd1);
            chk("rdata", bus.o_riscv_timer_rdata, re.data);
            last_rdata = re.data;
         end else begin
            chk("rvalid_idle", 64'(bus.o_riscv_timer_rvalid), 64'd0);
            chk("rdata_hold", bus.o_riscv_timer_rdata, last_rdata);
         end
         if (mtip_q.size() > 0 && mtip_q[0].cyc == cyc - 1) begin
            me = mtip_q.pop_front();
            chk("mtip", 64'(bus.o_riscv_timer_mtip), 64'(me.val));
         end
      end
   end

   initial begin
      logic        w;
      logic        r;
      logic [1:0]  s;
      logic [63:0] wd;
      logic [7:0]  st;

      bus.i_riscv_timer_wren   = 1'b0;
      bus.i_riscv_timer_rden   = 1'b0;
      bus.i_riscv_timer_regsel = 2'd0;
      bus.i_riscv_timer_wdata  = '0;
      bus.i_riscv_timer_wstrb  = '0;
      m_mtime = '0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_ctrl  = 64'd1;
      m_cnt   = 0;

      // Reset values, then read every register select
      do_reset();
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd1, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd2, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd3, 64'd0, 8'd0);
      idle(2);

      // Prescaler divisor 3, then disable and confirm mtime frozen
      do_reset();
      step(1'b1, 1'b0, 2'd2, 64'h7, 8'hFF);
      idle(12);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b1, 1'b0, 2'd2, 64'h0, 8'hFF);
      idle(20);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd2, 64'd0, 8'd0);

      // Partial-strobe compare write, MTIP rise and fall
      do_reset();
      step(1'b1, 1'b0, 2'd1, 64'd10, 8'h01);
      step(1'b0, 1'b1, 2'd1, 64'd0, 8'd0);
      step(1'b1, 1'b0, 2'd1, 64'd10, 8'hFF);
      idle(12);
      step(1'b1, 1'b0, 2'd1, 64'd100, 8'hFF);
      idle(3);

      // mtime wrap and write-over-tick priority
      step(1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b1, 1'b0, 2'd0, 64'd5, 8'hFF);
      step(1'b0, 1'b1, 2'd0, 64'd0, 8'd0);
      step(1'b1, 1'b0, 2'd3, 64'hDEAD, 8'hFF);
      step(1'b0, 1'b1, 2'd3, 64'd0, 8'd0);

      // Same-cycle read and write returns the old value
      step(1'b1, 1'b0, 2'd1, 64'h20, 8'hFF);
      step(1'b1, 1'b1, 2'd1, 64'h40, 8'hFF);
      step(1'b0, 1'b1, 2'd1, 64'd0, 8'd0);
      step(1'b1, 1'b0, 2'd1, 64'h77, 8'h00);
      step(1'b0, 1'b1, 2'd1, 64'd0, 8'd0);

      // Reset while a read is in flight
      step(1'b0, 1'b1, 2'd1, 64'd0, 8'd0);
      do_reset();
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         w  = ($urandom_range(0, 3) == 0);
         r  = 1'($urandom_range(0, 1));
         s  = 2'($urandom_range(0, 3));
         wd = {$urandom(), $urandom()};
         st = 8'($urandom());
         if (s == 2'd2) wd = 64'($urandom_range(0, 15));
         else if (s != 2'd3 && $urandom_range(0, 1) == 1) wd = 64'($urandom_range(0, 300));
         step(w, r, s, wd, st);
      end
      idle(3);

      chk("rd_drain", 64'(rd_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
